// File: rtl/action_input_pkg.sv
// Types and helpers for the keyboard-driven poker action entry block.
package action_input_pkg;

  `include "poker_types.svh"

  localparam int unsigned CHIP_W = 11;

  typedef logic [CHIP_W-1:0] chips_t;

  typedef enum logic [3:0] {
    KC_NONE,
    KC_DIGIT,
    KC_FOLD,
    KC_CALL,
    KC_BET,
    KC_RAISE,
    KC_ENTER,
    KC_ESC,
    KC_BKSP,
    KC_OTHER
  } key_class_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_ISSUE
  } state_t;

  // Clamp a wide intermediate chip count to the acting player's stack (all-in).
  function automatic chips_t clamp_to_stack(input logic [14:0] value, input chips_t stack);
    return (value > {4'd0, stack}) ? stack : value[CHIP_W-1:0];
  endfunction

endpackage

// File: rtl/key_event.sv
// Turns a held-key keycode stream into single-cycle key events and classifies the key.
module key_event
  import action_input_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] keycode,
  output logic       evt,
  output logic       is_digit,
  output logic [3:0] digit,
  output key_class_t key_class
);

  logic [7:0] keycode_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      keycode_q <= 8'h00;
    end else begin
      keycode_q <= keycode;
    end
  end

  assign evt = (keycode != 8'h00) && (keycode != keycode_q);

  always_comb begin
    is_digit  = 1'b0;
    digit     = 4'd0;
    key_class = KC_OTHER;
    case (keycode)
      8'h00:     key_class = KC_NONE;
      KEY_F:     key_class = KC_FOLD;
      KEY_C:     key_class = KC_CALL;
      KEY_B:     key_class = KC_BET;
      KEY_R:     key_class = KC_RAISE;
      KEY_ENTER: key_class = KC_ENTER;
      KEY_ESC:   key_class = KC_ESC;
      KEY_BKSP:  key_class = KC_BKSP;
      KEY_0:     begin is_digit = 1'b1; digit = 4'd0; key_class = KC_DIGIT; end
      KEY_1:     begin is_digit = 1'b1; digit = 4'd1; key_class = KC_DIGIT; end
      KEY_2:     begin is_digit = 1'b1; digit = 4'd2; key_class = KC_DIGIT; end
      KEY_3:     begin is_digit = 1'b1; digit = 4'd3; key_class = KC_DIGIT; end
      KEY_4:     begin is_digit = 1'b1; digit = 4'd4; key_class = KC_DIGIT; end
      KEY_5:     begin is_digit = 1'b1; digit = 4'd5; key_class = KC_DIGIT; end
      KEY_6:     begin is_digit = 1'b1; digit = 4'd6; key_class = KC_DIGIT; end
      KEY_7:     begin is_digit = 1'b1; digit = 4'd7; key_class = KC_DIGIT; end
      KEY_8:     begin is_digit = 1'b1; digit = 4'd8; key_class = KC_DIGIT; end
      KEY_9:     begin is_digit = 1'b1; digit = 4'd9; key_class = KC_DIGIT; end
      default:   key_class = KC_OTHER;
    endcase
  end

endmodule

// File: rtl/poker_types.svh
// Shared poker action encoding and USB HID keycodes used by the action entry logic.
`ifndef POKER_TYPES_SVH
`define POKER_TYPES_SVH

typedef enum logic [2:0] {
  FOLD  = 3'd0,
  CHECK = 3'd1,
  CALL  = 3'd2,
  BET   = 3'd3,
  RAISE = 3'd4
} action_t;

localparam logic [7:0] KEY_B     = 8'h05;
localparam logic [7:0] KEY_C     = 8'h06;
localparam logic [7:0] KEY_F     = 8'h09;
localparam logic [7:0] KEY_R     = 8'h15;
localparam logic [7:0] KEY_1     = 8'h1E;
localparam logic [7:0] KEY_2     = 8'h1F;
localparam logic [7:0] KEY_3     = 8'h20;
localparam logic [7:0] KEY_4     = 8'h21;
localparam logic [7:0] KEY_5     = 8'h22;
localparam logic [7:0] KEY_6     = 8'h23;
localparam logic [7:0] KEY_7     = 8'h24;
localparam logic [7:0] KEY_8     = 8'h25;
localparam logic [7:0] KEY_9     = 8'h26;
localparam logic [7:0] KEY_0     = 8'h27;
localparam logic [7:0] KEY_ENTER = 8'h28;
localparam logic [7:0] KEY_ESC   = 8'h29;
localparam logic [7:0] KEY_BKSP  = 8'h2A;

`endif

// File: rtl/action_input.sv
// Keyboard front end for the poker table: turns key events into a FOLD/CHECK/CALL/BET/RAISE
// action with an amount, offered to the poker FSM over a valid/ready handshake.
module action_input
  import action_input_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [7:0]             keycode,
  input  logic                   if_BetCheck,
  input  logic                   current_player,
  input  logic                   wait_state,
  input  logic [1:0][CHIP_W-1:0] player_stacks,
  input  logic [1:0][CHIP_W-1:0] player_pots,
  output logic                   action_valid,
  input  logic                   action_ready,
  output action_t                action,
  output logic [CHIP_W-1:0]      amount,
  output logic                   entry_active,
  output logic [CHIP_W-1:0]      entry_amount
);

  logic       evt;
  logic       is_digit;
  logic [3:0] digit;
  key_class_t key_class;

  key_event u_key_event (
    .clk       (clk),
    .reset_n   (reset_n),
    .keycode   (keycode),
    .evt       (evt),
    .is_digit  (is_digit),
    .digit     (digit),
    .key_class (key_class)
  );

  state_t state_q, state_d;
  logic   valid_d;
  action_t action_d;
  chips_t amount_d, entry_d;
  logic   entry_player_q, entry_player_d;

  chips_t      own_stack, own_pot, opp_pot, call_gap, call_amount;
  logic [14:0] digit_sum;

  assign own_stack = player_stacks[current_player];
  assign own_pot   = player_pots[current_player];
  assign opp_pot   = player_pots[!current_player];
  assign call_gap  = opp_pot - own_pot;

  // A negative gap (already matched or ahead) calls nothing.
  assign call_amount = (opp_pot > own_pot) ? clamp_to_stack({4'd0, call_gap}, own_stack) : '0;
  assign digit_sum   = 15'(entry_amount) * 15'd10 + 15'(digit);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d        = state_q;
    valid_d        = action_valid;
    action_d       = action;
    amount_d       = amount;
    entry_d        = entry_amount;
    entry_player_d = entry_player_q;

    case (state_q)
      ST_IDLE: begin
        if (evt && !wait_state) begin
          case (key_class)
            KC_FOLD: begin
              action_d = FOLD;
              amount_d = '0;
              valid_d  = 1'b1;
              state_d  = ST_ISSUE;
            end
            KC_CALL: begin
              action_d = if_BetCheck ? CHECK : CALL;
              amount_d = if_BetCheck ? '0 : call_amount;
              valid_d  = 1'b1;
              state_d  = ST_ISSUE;
            end
            KC_BET, KC_RAISE: begin
              if ((key_class == KC_BET) == if_BetCheck) begin
                entry_d        = '0;
                entry_player_d = current_player;
                state_d        = ST_ENTRY;
              end
            end
            default: ;
          endcase
        end
      end

      ST_ENTRY: begin
        // Leaving the table or a seat change invalidates the half-typed amount.
        if (wait_state || (current_player != entry_player_q)) begin
          entry_d = '0;
          state_d = ST_IDLE;
        end else if (evt && is_digit) begin
          entry_d = clamp_to_stack(digit_sum, own_stack);
        end else if (evt) begin
          case (key_class)
            KC_BKSP: entry_d = entry_amount / CHIP_W'(10);
            KC_ESC: begin
              entry_d = '0;
              state_d = ST_IDLE;
            end
            KC_ENTER: begin
              if (entry_amount != '0) begin
                action_d = if_BetCheck ? BET : RAISE;
                amount_d = entry_amount;
                valid_d  = 1'b1;
                state_d  = ST_ISSUE;
              end
            end
            default: ;
          endcase
        end
      end

      ST_ISSUE: begin
        if (action_valid && action_ready) begin
          valid_d = 1'b0;
          entry_d = '0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      action_valid   <= 1'b0;
      action         <= CHECK;
      amount         <= '0;
      entry_amount   <= '0;
      entry_player_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      action_valid   <= valid_d;
      action         <= action_d;
      amount         <= amount_d;
      entry_amount   <= entry_d;
      entry_player_q <= entry_player_d;
    end
  end

  assign entry_active = (state_q == ST_ENTRY);

endmodule

// File: doc/action_input.md
ACTION_INPUT -- requirements
Module: action_input

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; reset_n in 1, synchronous active-low reset.
REQ-002 SHALL have keycode in 8, USB HID keycode of the currently held key; 0x00 means none.
REQ-003 SHALL have if_BetCheck in 1, where 1 offers Bet/Check and 0 offers Raise/Call, matching the on-screen buttons.
REQ-004 SHALL have these game-state inputs:
- current_player in 1, acting seat;
- wait_state in 1, inter-hand blank screen;
- player_stacks in 2x11, chips per seat;
- player_pots in 2x11, chips committed this street per seat.
REQ-005 SHALL have action_valid out 1, action ready; action_ready in 1, accepted by the poker FSM.
REQ-006 SHALL have action out action_t (FOLD, CHECK, CALL, BET, RAISE) and amount out 11, chips added.
REQ-007 SHALL have entry_active out 1, amount entry open; entry_amount out 11, digits typed so far, for display.

Function
REQ-008 SHALL define a key event as keycode nonzero and different from its value registered on the previous clk; held keys produce exactly one event.
REQ-009 SHALL implement states IDLE, ENTRY and ISSUE.
REQ-010 IDLE, when wait_state=1, SHALL ignore all events.
REQ-011 IDLE, when wait_state=0, SHALL respond to these keys:
- 'F' (0x09): action=FOLD, amount=0, go to ISSUE;
- 'C' (0x06) with if_BetCheck=1: action=CHECK, amount=0, go to ISSUE;
- 'C' (0x06) with if_BetCheck=0: action=CALL, go to ISSUE;
- 'B' (0x05) with if_BetCheck=1, or 'R' (0x15) with if_BetCheck=0: go to ENTRY, entry_amount=0;
- any other key, including B/R mismatched to if_BetCheck: ignored.
REQ-012 CALL amount SHALL be opp_pot - own_pot, clamped to [0, own stack]; own = player at current_player, opp = the other seat.
REQ-013 ENTRY digit keys SHALL be '1'..'9' (0x1E-0x26) = 1..9 and '0' (0x27) = 0.
REQ-014 ENTRY digit handling SHALL be:
- compute entry_amount*10+d at 15-bit width;
- if the result exceeds own stack, entry_amount = own stack (all-in clamp);
- otherwise entry_amount = result.
REQ-015 ENTRY Backspace (0x2A) SHALL set entry_amount = entry_amount/10, integer division.
REQ-016 ENTRY Escape (0x29) SHALL return to IDLE with entry_amount=0.
REQ-017 ENTRY Enter (0x28) handling SHALL be:
- entry_amount=0: ignored;
- otherwise: action=BET if if_BetCheck=1, else RAISE; amount=entry_amount; go to ISSUE.
REQ-018 ENTRY SHALL abort to IDLE (entry_amount=0) if wait_state rises or current_player changes; abort takes priority over a simultaneous key event.
REQ-019 ISSUE handshake SHALL be:
- action_valid=1; action and amount held stable;
- all key events and abort conditions ignored;
- leave only on action_valid && action_ready, sampled on the same clk, then go to IDLE with entry_amount=0 and action_valid=0 next cycle.
REQ-020 action_valid SHALL rise exactly one clk after the triggering key event's registration edge, giving one-cycle latency.
REQ-021 action_ready while not in ISSUE SHALL be ignored.
REQ-022 entry_active SHALL be 1 exactly when the state is ENTRY.

Reset
REQ-023 reset_n=0 at a clk edge SHALL force the following, regardless of state, including mid-handshake:
- state=IDLE;
- action_valid=0, action=CHECK, amount=0;
- entry_amount=0, entry_active=0;
- registered keycode=0x00.
REQ-024 A key held through reset release SHALL produce one event on the first post-reset cycle.

Structure
REQ-025 action_t and the keycode constants (KEY_F, KEY_C, KEY_B, KEY_R, KEY_0..KEY_9, KEY_ENTER, KEY_ESC, KEY_BKSP) SHALL live in poker_types.svh.
REQ-026 Edge detection and classification SHALL be a sub-module key_event, outputs: event, is_digit, digit[3:0], key class; action_input holds the FSM and arithmetic.

Verification
REQ-027 Fold scenario: IDLE, if_BetCheck=1, key 'F' held 20 cycles, action_ready=1 -> exactly one FOLD/amount 0 handshake.
REQ-028 Call scenario: if_BetCheck=0, pots {40,100}, stacks {50,500}, current_player=0, key 'C' -> CALL amount 50 (stack clamp from 60).
REQ-029 Bet scenario: if_BetCheck=1, stack 1000, keys B,1,2,5,Backspace,7,Enter -> BET amount 127, with entry_amount showing 0,1,12,125,12,127.
REQ-030 Clamp and hold scenario: stack 300, keys B,9,9,9 -> entry_amount 300; Enter with action_ready=0 for 5 cycles -> valid held 5 cycles, stable RAISE/BET 300, extra keys ignored; ready=1 -> IDLE.
REQ-031 Abort scenario: ENTRY with entry_amount 45, then wait_state=1 in the same cycle as key '6' -> IDLE, entry_amount 0, no action.
REQ-032 Reset scenario: reset_n=0 during ISSUE -> action_valid=0 next edge, all outputs at reset values.
